uop_issue_scheduler: RTL and testbench

- In-order, single-issue scheduler between decode and execute.
- Holds one decoded micro-op (riscv_uop_pkg::uop_t) and tracks pending register writes in a 32-bit scoreboard.
- Dispatches each uop to the ALU or the LSU with valid/ready handshakes once it is free of hazards.
- Shares the single issue slot between the two units and enforces an LSU outstanding-request limit.

---
 rtl/riscv_uop_pkg.sv | 31 +++
 rtl/uop_issue_scheduler_if.sv | 48 ++++
 rtl/uop_issue_scheduler.sv | 129 ++++++++++++
 tb/tb_uop_issue_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_uop_pkg.sv
// Decoded micro-op format shared by decode, the issue scheduler and the execute units.
package riscv_uop_pkg;

  typedef enum logic [3:0] {
    OPCODE_INVALID = 4'd0,
    OPCODE_OP      = 4'd1,
    OPCODE_OP_IMM  = 4'd2,
    OPCODE_LUI     = 4'd3,
    OPCODE_AUIPC   = 4'd4,
    OPCODE_BRANCH  = 4'd5,
    OPCODE_JAL     = 4'd6,
    OPCODE_JALR    = 4'd7,
    OPCODE_LOAD    = 4'd8,
    OPCODE_STORE   = 4'd9
  } opcode_e;

  typedef struct packed {
    logic        valid;
    opcode_e     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        is_load;
    logic        is_store;
    logic [11:0] imm;
  } uop_t;

endpackage

// File: rtl/uop_issue_scheduler_if.sv
// Issue-stage bundle between decode, the scheduler and the ALU/LSU.
// slave  : scheduler side (consumes decode, drives dispatch)
// master : environment side (decode, execute units, writeback, flush)
// Signals: uop_valid_i/uop_ready_o/uop_i decode handshake; alu_*/lsu_* dispatch
// handshakes; lsu_done_i LSU retire pulse; wb_valid_i/wb_rd_i writeback;
// flush_i redirect; illegal_o discard pulse.
// ISSUE_PERF_CNT_EN adds stall_raw_cnt_o / stall_unit_cnt_o.
interface uop_issue_scheduler_if;
  import riscv_uop_pkg::*;

  logic        uop_valid_i;
  logic        uop_ready_o;
  uop_t        uop_i;
  logic        alu_valid_o;
  logic        alu_ready_i;
  uop_t        alu_uop_o;
  logic        lsu_valid_o;
  logic        lsu_ready_i;
  uop_t        lsu_uop_o;
  logic        lsu_done_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic        illegal_o;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] stall_raw_cnt_o;
  logic [31:0] stall_unit_cnt_o;
`endif

  modport slave (
    input  uop_valid_i, uop_i, alu_ready_i, lsu_ready_i, lsu_done_i,
           wb_valid_i, wb_rd_i, flush_i,
`ifdef ISSUE_PERF_CNT_EN
    output stall_raw_cnt_o, stall_unit_cnt_o,
`endif
    output uop_ready_o, alu_valid_o, alu_uop_o, lsu_valid_o, lsu_uop_o, illegal_o
  );

  modport master (
    output uop_valid_i, uop_i, alu_ready_i, lsu_ready_i, lsu_done_i,
           wb_valid_i, wb_rd_i, flush_i,
`ifdef ISSUE_PERF_CNT_EN
    input  stall_raw_cnt_o, stall_unit_cnt_o,
`endif
    input  uop_ready_o, alu_valid_o, alu_uop_o, lsu_valid_o, lsu_uop_o, illegal_o
  );

endinterface

// File: rtl/uop_issue_scheduler.sv
// In-order single-issue scheduler: holds one decoded uop, checks it against a
// register-busy scoreboard and dispatches it to the ALU or LSU.
// Ports: clk, rst (async, active high), bus (uop_issue_scheduler_if.slave).
// Optional: ISSUE_PERF_CNT_EN adds RAW/WAW and unit-stall cycle counters.
//
// state | meaning
// ------+----------------------------------
// EMPTY | hold register free
// HOLD  | uop latched, waiting for dispatch
module uop_issue_scheduler
  import riscv_uop_pkg::*;
#(
  parameter int unsigned LSU_MAX_OUTSTANDING = 2,
  parameter int unsigned NUM_REGS            = 32
) (
  input logic                  clk,
  input logic                  rst,
  uop_issue_scheduler_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [2:0] LSU_MAX = 3'(LSU_MAX_OUTSTANDING);

  state_e              state_q, state_d;
  uop_t                hold_q, hold_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          lsu_cnt_q, lsu_cnt_d;

  logic in_hold, to_lsu, to_alu, bad, hazard, lsu_room;
  logic alu_valid, lsu_valid, alu_fire, lsu_fire, fire, discard, ready, accept;

  always_comb begin
    in_hold  = (state_q == HOLD);
    to_lsu   = hold_q.is_load | hold_q.is_store;
    to_alu   = hold_q.opcode inside {OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC,
                                     OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR};
    // Anything that routes to neither unit is treated like an invalid uop.
    bad      = !hold_q.valid || (hold_q.opcode == OPCODE_INVALID) || !(to_lsu || to_alu);
    // Only registered busy bits are used; a writeback releases the stall next cycle.
    hazard   = (hold_q.uses_rs1  && busy_q[hold_q.rs1]) ||
               (hold_q.uses_rs2  && busy_q[hold_q.rs2]) ||
               (hold_q.writes_rd && busy_q[hold_q.rd]);
    lsu_room = (lsu_cnt_q < LSU_MAX);

    alu_valid = in_hold && !bus.flush_i && !bad && !to_lsu && !hazard;
    lsu_valid = in_hold && !bus.flush_i && !bad &&  to_lsu && !hazard && lsu_room;
    alu_fire  = alu_valid && bus.alu_ready_i;
    lsu_fire  = lsu_valid && bus.lsu_ready_i;
    fire      = alu_fire || lsu_fire;
    discard   = in_hold && !bus.flush_i && bad;
    ready     = !bus.flush_i && (!in_hold || fire || discard);
    accept    = bus.uop_valid_i && ready;

    state_d = state_q;
    hold_d  = hold_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
      hold_d  = '0;
    end else if (accept) begin
      state_d = HOLD;
      hold_d  = bus.uop_i;
    end else if (fire || discard) begin
      state_d = EMPTY;
    end

    busy_d = busy_q;
    if (bus.wb_valid_i) busy_d[bus.wb_rd_i] = 1'b0;
    // Set after clear so a same-cycle dispatch to the written-back rd stays busy.
    if (fire && hold_q.writes_rd && (hold_q.rd != 5'd0)) busy_d[hold_q.rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (bus.flush_i) busy_d = '0;

    lsu_cnt_d = lsu_cnt_q;
    if (lsu_fire && !(bus.lsu_done_i && (lsu_cnt_q != 3'd0))) begin
      lsu_cnt_d = lsu_cnt_q + 3'd1;
    end else if (!lsu_fire && bus.lsu_done_i && (lsu_cnt_q != 3'd0)) begin
      lsu_cnt_d = lsu_cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      hold_q    <= '0;
      busy_q    <= '0;
      lsu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      lsu_cnt_q <= lsu_cnt_d;
    end
  end

  assign bus.uop_ready_o = ready;
  assign bus.alu_valid_o = alu_valid;
  assign bus.lsu_valid_o = lsu_valid;
  assign bus.alu_uop_o   = in_hold ? hold_q : '0;
  assign bus.lsu_uop_o   = in_hold ? hold_q : '0;
  assign bus.illegal_o   = discard;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] raw_cnt_q, raw_cnt_d, unit_cnt_q, unit_cnt_d;

  always_comb begin
    raw_cnt_d  = raw_cnt_q;
    unit_cnt_d = unit_cnt_q;
    if (in_hold && !bus.flush_i && !bad) begin
      if (hazard)     raw_cnt_d  = raw_cnt_q + 32'd1;
      else if (!fire) unit_cnt_d = unit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_cnt_q  <= '0;
      unit_cnt_q <= '0;
    end else begin
      raw_cnt_q  <= raw_cnt_d;
      unit_cnt_q <= unit_cnt_d;
    end
  end

  assign bus.stall_raw_cnt_o  = raw_cnt_q;
  assign bus.stall_unit_cnt_o = unit_cnt_q;
`endif

endmodule

// File: tb/tb_uop_issue_scheduler.sv
module tb_uop_issue_scheduler;
  import riscv_uop_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uop_issue_scheduler_if bus();

  uop_issue_scheduler #(.LSU_MAX_OUTSTANDING(2), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic to_lsu;
    uop_t u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic uop_t mk(opcode_e op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic w, logic [11:0] imm);
    uop_t u;
    u           = '0;
    u.valid     = 1'b1;
    u.opcode    = op;
    u.rd        = rd;
    u.rs1       = rs1;
    u.rs2       = rs2;
    u.uses_rs1  = u1;
    u.uses_rs2  = u2;
    u.writes_rd = w;
    u.is_load   = (op == OPCODE_LOAD);
    u.is_store  = (op == OPCODE_STORE);
    u.imm       = imm;
    return u;
  endfunction

  task automatic push(logic lsu, uop_t u);
    exp_t e;
    e.to_lsu = lsu;
    e.u      = u;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(logic lsu, uop_t u);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_dispatch: unit lsu=%0b uop %h, expected none at %0t", lsu, u, $time);
    end else begin
      e = exp_q.pop_front();
      chk("dispatch_unit", 64'(lsu), 64'(e.to_lsu));
      chk("dispatch_uop", 64'(u), 64'(e.u));
    end
  endtask

  // Monitor: every handshake on either unit consumes the next expected dispatch.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.alu_valid_o && bus.alu_ready_i) pop_cmp(1'b0, bus.alu_uop_o);
      if (bus.lsu_valid_o && bus.lsu_ready_i) pop_cmp(1'b1, bus.lsu_uop_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic offer(uop_t u);
    bus.uop_valid_i = 1'b1;
    bus.uop_i       = u;
  endtask

  task automatic wb(logic v, logic [4:0] rd);
    bus.wb_valid_i = v;
    bus.wb_rd_i    = rd;
  endtask

  uop_t add5, addi6, add3, bad, add4, inv, lw11, lw12, lw13, lw14;
  uop_t addi0, add9, use9, use0, add7, use7;

  initial begin
    add5  = mk(OPCODE_OP,     5'd5,  5'd1, 5'd2, 1, 1, 1, 12'h005);
    addi6 = mk(OPCODE_OP_IMM, 5'd6,  5'd5, 5'd0, 1, 0, 1, 12'h001);
    add3  = mk(OPCODE_OP,     5'd3,  5'd1, 5'd2, 1, 1, 1, 12'h033);
    bad   = mk(OPCODE_OP,     5'd4,  5'd1, 5'd2, 1, 1, 1, 12'hbad);
    bad.valid = 1'b0;
    add4  = mk(OPCODE_OP,     5'd4,  5'd1, 5'd2, 1, 1, 1, 12'h044);
    inv   = mk(OPCODE_INVALID,5'd0,  5'd0, 5'd0, 0, 0, 0, 12'hfff);
    lw11  = mk(OPCODE_LOAD,   5'd11, 5'd2, 5'd0, 1, 0, 1, 12'h011);
    lw12  = mk(OPCODE_LOAD,   5'd12, 5'd2, 5'd0, 1, 0, 1, 12'h012);
    lw13  = mk(OPCODE_LOAD,   5'd13, 5'd2, 5'd0, 1, 0, 1, 12'h013);
    lw14  = mk(OPCODE_LOAD,   5'd14, 5'd2, 5'd0, 1, 0, 1, 12'h014);
    addi0 = mk(OPCODE_OP_IMM, 5'd0,  5'd1, 5'd0, 1, 0, 1, 12'h000);
    add9  = mk(OPCODE_OP,     5'd9,  5'd1, 5'd2, 1, 1, 1, 12'h099);
    use9  = mk(OPCODE_OP,     5'd10, 5'd9, 5'd1, 1, 1, 1, 12'h0a0);
    use0  = mk(OPCODE_OP,     5'd15, 5'd0, 5'd0, 1, 1, 1, 12'h0f0);
    add7  = mk(OPCODE_OP,     5'd7,  5'd1, 5'd2, 1, 1, 1, 12'h077);
    use7  = mk(OPCODE_OP_IMM, 5'd8,  5'd7, 5'd0, 1, 0, 1, 12'h088);

    bus.uop_valid_i = 1'b0;
    bus.uop_i       = '0;
    bus.alu_ready_i = 1'b1;
    bus.lsu_ready_i = 1'b1;
    bus.lsu_done_i  = 1'b0;
    bus.wb_valid_i  = 1'b0;
    bus.wb_rd_i     = 5'd0;
    bus.flush_i     = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_alu_valid", 64'(bus.alu_valid_o), 0);
    chk("rst_lsu_valid", 64'(bus.lsu_valid_o), 0);
    chk("rst_illegal", 64'(bus.illegal_o), 0);
    chk("rst_uop_ready", 64'(bus.uop_ready_o), 1);
    chk("rst_alu_uop", 64'(bus.alu_uop_o), 0);
    chk("rst_lsu_uop", 64'(bus.lsu_uop_o), 0);
    nxt();
    rst = 1'b0;

    // ADD x5 issues next cycle; dependent ADDI x6,x5 waits for wb of x5
    nxt(); offer(add5); settle(); chk("add5_accept", 64'(bus.uop_ready_o), 1); push(0, add5);
    nxt(); bus.uop_valid_i = 0; settle();
    chk("add5_valid", 64'(bus.alu_valid_o), 1);
    chk("add5_uop", 64'(bus.alu_uop_o), 64'(add5));
    nxt(); offer(addi6); settle(); chk("addi6_accept", 64'(bus.uop_ready_o), 1); push(0, addi6);
    nxt(); bus.uop_valid_i = 0; settle(); chk("raw_stall1", 64'(bus.alu_valid_o), 0);
    nxt(); settle(); chk("raw_stall2", 64'(bus.alu_valid_o), 0);
    nxt(); wb(1, 5'd5); settle(); chk("raw_no_bypass", 64'(bus.alu_valid_o), 0);
    nxt(); wb(0, 5'd0); settle(); chk("raw_release", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd6);
    nxt(); wb(0, 5'd0);

    // ALU back-pressure: valid holds with a stable uop
    nxt(); offer(add3); push(0, add3);
    nxt(); bus.uop_valid_i = 0; bus.alu_ready_i = 0; settle();
    chk("bp_valid1", 64'(bus.alu_valid_o), 1);
    chk("bp_not_ready", 64'(bus.uop_ready_o), 0);
    nxt(); settle();
    chk("bp_valid2", 64'(bus.alu_valid_o), 1);
    chk("bp_uop_stable", 64'(bus.alu_uop_o), 64'(add3));
    nxt(); bus.alu_ready_i = 1; settle(); chk("bp_valid3", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd3);
    nxt(); wb(0, 5'd0);

    // invalid uop discarded, next uop accepted in the discard cycle
    nxt(); offer(bad);
    nxt(); offer(add4); settle();
    chk("ill_pulse", 64'(bus.illegal_o), 1);
    chk("ill_no_dispatch", 64'(bus.alu_valid_o), 0);
    chk("ill_ready", 64'(bus.uop_ready_o), 1);
    push(0, add4);
    nxt(); bus.uop_valid_i = 0; settle();
    chk("ill_pulse_end", 64'(bus.illegal_o), 0);
    chk("ill_next_issue", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd4); offer(inv);
    nxt(); wb(0, 5'd0); bus.uop_valid_i = 0; settle();
    chk("inv_op_pulse", 64'(bus.illegal_o), 1);
    chk("inv_op_no_lsu", 64'(bus.lsu_valid_o), 0);
    nxt(); settle(); chk("inv_op_pulse_end", 64'(bus.illegal_o), 0);

    // three loads against an outstanding limit of two
    nxt(); offer(lw11); push(1, lw11);
    nxt(); offer(lw12); settle();
    chk("lw11_valid", 64'(bus.lsu_valid_o), 1);
    chk("lw11_b2b_ready", 64'(bus.uop_ready_o), 1);
    push(1, lw12);
    nxt(); offer(lw13); settle(); chk("lw12_valid", 64'(bus.lsu_valid_o), 1); push(1, lw13);
    nxt(); bus.uop_valid_i = 0; settle(); chk("lsu_limit1", 64'(bus.lsu_valid_o), 0);
    nxt(); settle(); chk("lsu_limit2", 64'(bus.lsu_valid_o), 0);
    nxt(); bus.lsu_done_i = 1; settle(); chk("lsu_limit3", 64'(bus.lsu_valid_o), 0);
    nxt(); bus.lsu_done_i = 0; settle(); chk("lsu_release", 64'(bus.lsu_valid_o), 1);
    nxt(); bus.lsu_done_i = 1; wb(1, 5'd11);
    nxt(); wb(1, 5'd12);
    nxt(); wb(1, 5'd13);
    nxt(); bus.lsu_done_i = 0; wb(1, 5'd0); offer(lw14); push(1, lw14);
    nxt(); bus.uop_valid_i = 0; wb(0, 5'd0); settle();
    chk("lsu_no_underflow", 64'(bus.lsu_valid_o), 1);
    nxt(); bus.lsu_done_i = 1; wb(1, 5'd14);
    nxt(); bus.lsu_done_i = 0; wb(0, 5'd0);

    // x0 never tracked; same-cycle set and clear of x9: set wins
    nxt(); offer(addi0); push(0, addi0);
    nxt(); offer(add9); settle(); chk("addi0_valid", 64'(bus.alu_valid_o), 1); push(0, add9);
    nxt(); offer(use9); wb(1, 5'd9); settle(); chk("add9_valid", 64'(bus.alu_valid_o), 1); push(0, use9);
    nxt(); bus.uop_valid_i = 0; wb(0, 5'd0); settle(); chk("set_wins1", 64'(bus.alu_valid_o), 0);
    nxt(); wb(1, 5'd9); settle(); chk("set_wins2", 64'(bus.alu_valid_o), 0);
    nxt(); wb(0, 5'd0); settle(); chk("x9_release", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd10); offer(use0); push(0, use0);
    nxt(); wb(0, 5'd0); bus.uop_valid_i = 0; settle(); chk("x0_never_busy", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd15);
    nxt(); wb(0, 5'd0);

    // flush while a uop waits on busy x7
    nxt(); offer(add7); push(0, add7);
    nxt(); offer(use7); settle(); chk("add7_valid", 64'(bus.alu_valid_o), 1);
    nxt(); offer(add4); bus.flush_i = 1; settle();
    chk("flush_ready", 64'(bus.uop_ready_o), 0);
    chk("flush_valid", 64'(bus.alu_valid_o), 0);
    nxt(); bus.flush_i = 0; bus.uop_valid_i = 0; settle();
    chk("post_flush_alu", 64'(bus.alu_valid_o), 0);
    chk("post_flush_lsu", 64'(bus.lsu_valid_o), 0);
    chk("post_flush_ready", 64'(bus.uop_ready_o), 1);
    nxt(); offer(use7); push(0, use7);
    nxt(); bus.uop_valid_i = 0; settle(); chk("flush_cleared_busy", 64'(bus.alu_valid_o), 1);
    nxt(); wb(1, 5'd8);
    nxt(); wb(0, 5'd0);

    // asynchronous reset while a uop is held
    nxt(); offer(add3);
    nxt(); bus.uop_valid_i = 0; bus.alu_ready_i = 0; settle();
    chk("pre_rst_valid", 64'(bus.alu_valid_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.alu_valid_o), 0);
    chk("async_rst_ready", 64'(bus.uop_ready_o), 1);
    chk("async_rst_uop", 64'(bus.alu_uop_o), 0);
    nxt(); rst = 1'b0; bus.alu_ready_i = 1;
    nxt(); nxt(); settle();
    chk("no_ghost_valid", 64'(bus.alu_valid_o), 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
